config_loader: RTL and testbench
================================

// Module: config_loader
// PURPOSE
//  Upstream stage of the logic grid: receives the configuration bitstream as a
//  stream of words over a valid/ready handshake and assembles it into the
//  parallel config bus driven into the grid's config_in. Holds the grid in reset
//  (grid_nreset) until a complete and, optionally, CRC-checked bitstream is loaded.
// PARAMETERS
//  CONFIG_WIDTH  1314  width of config_out; equals the grid's config_in width
//  WORD_WIDTH    32    width of one bitstream word
//  NUM_WORDS     ceil(CONFIG_WIDTH/WORD_WIDTH) = 42 (derived localparam)
// PORTS
//  clock        in   1             single clock, all logic rising-edge
//  nreset       in   1             asynchronous active-low reset
//  start        in   1             pulse: begin a new load, discarding the current one
//  data_in      in   WORD_WIDTH    bitstream word
//  data_valid   in   1             data_in is valid
//  data_ready   out  1             loader accepts data_in this cycle
//  config_out   out  CONFIG_WIDTH  assembled configuration bus to the grid
//  config_done  out  1             full bitstream loaded and accepted
//  error        out  1             CRC mismatch on the last load
//  grid_nreset  out  1             active-low reset for the grid; high only in DONE
// BEHAVIOUR
//  - Reset (nreset=0, async): state=IDLE; shift reg, word counter = 0;
//    config_out=0, data_ready=0, config_done=0, error=0, grid_nreset=0.
//  - Transfer: word accepted iff data_valid & data_ready on a rising edge.
//    data_ready is decoded from state: 1 in LOAD and CHECK, 0 elsewhere.
//  - Storage: NUM_WORDS*WORD_WIDTH shift reg; each accepted word enters at the
//    top, reg shifts right by WORD_WIDTH. After NUM_WORDS words, word k occupies
//    bits [k*WORD_WIDTH +: WORD_WIDTH]. config_out = reg[CONFIG_WIDTH-1:0].
//    Upper (NUM_WORDS*WORD_WIDTH - CONFIG_WIDTH) = 30 bits of the last word are padding.
//  - States:
//    IDLE : waits for start -> LOAD.
//    LOAD : accepts data words; counter increments per word (0..NUM_WORDS-1). Accepting
//           the word with counter=NUM_WORDS-1 -> DONE (or CHECK with CRC).
//    CHECK: (CRC build only) accepts one trailing word -> DONE if match, else ERROR.
//    DONE : config_done=1; grid_nreset=1 (registered, rises 1 cycle after entry).
//    ERROR: error=1; config_done=0; grid_nreset=0.
//  - start in any state -> LOAD next cycle: shift reg and counter cleared, CRC
//    re-initialised, config_done, error and grid_nreset forced 0. A word handshaked
//    in the same cycle as start is discarded.
//  - data_valid low stalls LOAD/CHECK indefinitely; no timeout.
//  - config_out tracks the shift reg during LOAD (partial data); the grid is held
//    in reset meanwhile, so this is harmless.
//  - Reset mid-load: all state lost, a fresh start is required.
//  - Words presented outside LOAD/CHECK are not accepted (data_ready=0).
// CONFIGURATION
//  CONFIG_LOADER_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first,
//    no reflection, no final xor) computed over all NUM_WORDS data words incl. padding;
//    one extra word follows, its bits [15:0] compared to the CRC, bits [31:16] ignored.
//    Mismatch -> ERROR.
//  Not defined: no CHECK state, no CRC logic; error is constant 0; LOAD -> DONE directly.
// TESTING
//  1. Reset, start, 42 words k=0..41 with data_in=k, valid always 1 -> 42 handshakes;
//     config_out[31:0]=0, [63:32]=1; config_done=1 and grid_nreset=1 after the last word.
//  2. Valid toggled 1/0 every cycle over the same stream -> identical config_out,
//     done after 42 accepts (83 cycles); counter never advances on valid=0.
//  3. Last word 0xFFFFFFFF -> config_out[1313:1312]=2'b11, padding bits not exported.
//  4. start after 20 words, then 42 words of 0xA5A5A5A5 -> config_out all 0xA5A5... pattern,
//     no residue from the first 20 words; the word handshaked with start is dropped.
//  5. nreset pulsed low at word 30 -> all outputs 0 immediately (async); data_ready=0 until start.
//  6. (CRC_EN) correct CRC word -> DONE, error=0; CRC word with bit0 flipped -> ERROR,
//     error=1, grid_nreset=0; a following start clears error.

Source files
------------

// File: rtl/config_loader_if.sv
// config_loader_if
//   Bitstream stream and configuration-bus bundle between the bitstream source
//   and the config_loader.
//   master: bitstream source   -> drives start, data_in, data_valid
//   slave : config_loader      -> drives data_ready, config_out, config_done,
//                                 error, grid_nreset
//   start        pulse, begin a new load
//   data_in      one bitstream word
//   data_valid   data_in is valid
//   data_ready   loader accepts data_in this cycle
//   config_out   assembled configuration bus to the grid
//   config_done  full bitstream loaded and accepted
//   error        CRC mismatch on the last load
//   grid_nreset  active-low grid reset, released only once loading is done
interface config_loader_if #(
   parameter int WORD_WIDTH   = 32,
   parameter int CONFIG_WIDTH = 1314
);
   logic                    start;
   logic [WORD_WIDTH-1:0]   data_in;
   logic                    data_valid;
   logic                    data_ready;
   logic [CONFIG_WIDTH-1:0] config_out;
   logic                    config_done;
   logic                    error;
   logic                    grid_nreset;

   modport master (
      output start, data_in, data_valid,
      input  data_ready, config_out, config_done, error, grid_nreset
   );

   modport slave (
      input  start, data_in, data_valid,
      output data_ready, config_out, config_done, error, grid_nreset
   );
endinterface

// File: rtl/config_loader.sv
// config_loader
//   Receives the grid configuration bitstream as WORD_WIDTH words over a
//   valid/ready handshake and assembles it into the parallel config bus. The
//   grid is held in reset until a complete bitstream has been loaded.
//   Optional feature macro: CONFIG_LOADER_CRC_EN
//     defined   -> CRC-16-CCITT (0x1021, init 0xFFFF, MSB-first) over all data
//                  words; one trailing word carries the CRC in bits [15:0].
//     undefined -> no CRC check, error is tied low.
// Ports
//   clock   rising-edge clock
//   nreset  asynchronous active-low reset
//   bus     config_loader_if.slave (stream in, config bus and status out)
//
// state | meaning
// IDLE  | waiting for start, grid held in reset
// LOAD  | accepting data words into the shift register
// CHECK | accepting the trailing CRC word (CRC build only)
// DONE  | bitstream complete, grid released one cycle after entry
// ERROR | CRC mismatch, grid held in reset (CRC build only)
module config_loader #(
   parameter int CONFIG_WIDTH = 1314,
   parameter int WORD_WIDTH   = 32
) (
   input  logic           clock,
   input  logic           nreset,
   config_loader_if.slave bus
);
   localparam int NUM_WORDS   = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int TOTAL_WIDTH = NUM_WORDS * WORD_WIDTH;
   localparam int CNT_W       = $clog2(NUM_WORDS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

`ifdef CONFIG_LOADER_CRC_EN
   typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, DONE} state_t;
`endif

   state_t                 state;
   state_t                 next_state;
   logic [TOTAL_WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0]       word_cnt;
   logic                   grid_nreset_q;
   logic                   load_accept;
   logic                   last_word;

   // start wins over any handshake in the same cycle: that word is dropped.
   assign load_accept = bus.data_valid && (state == LOAD) && !bus.start;
   assign last_word   = (word_cnt == LAST_CNT);

`ifdef CONFIG_LOADER_CRC_EN
   logic        check_accept;
   logic        crc_match;
   logic [15:0] crc_q;

   function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                              input logic [WORD_WIDTH-1:0] word);
      logic [15:0] crc;
      crc = crc_in;
      for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
         if (crc[15] ^ word[i]) crc = {crc[14:0], 1'b0} ^ 16'h1021;
         else                   crc = {crc[14:0], 1'b0};
      end
      return crc;
   endfunction

   assign check_accept = bus.data_valid && (state == CHECK) && !bus.start;
   assign crc_match    = (bus.data_in[15:0] == crc_q);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)          crc_q <= 16'hFFFF;
      else if (bus.start)   crc_q <= 16'hFFFF;
      else if (load_accept) crc_q <= crc16_word(crc_q, bus.data_in);
   end

   assign bus.error      = (state == ERROR);
   assign bus.data_ready = (state == LOAD) || (state == CHECK);
`else
   assign bus.error      = 1'b0;
   assign bus.data_ready = (state == LOAD);
`endif

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (bus.start) begin
         next_state = LOAD;
      end else begin
         case (state)
            IDLE: next_state = IDLE;
            LOAD: begin
               if (load_accept && last_word) begin
`ifdef CONFIG_LOADER_CRC_EN
                  next_state = CHECK;
`else
                  next_state = DONE;
`endif
               end
            end
`ifdef CONFIG_LOADER_CRC_EN
            CHECK: begin
               if (check_accept) next_state = crc_match ? DONE : ERROR;
            end
            ERROR: next_state = ERROR;
`endif
            DONE:    next_state = DONE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Words enter at the top and shift right, so word k ends at bits
   // [k*WORD_WIDTH +: WORD_WIDTH] once all NUM_WORDS have arrived.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         shift_reg <= '0;
         word_cnt  <= '0;
      end else if (bus.start) begin
         shift_reg <= '0;
         word_cnt  <= '0;
      end else if (load_accept) begin
         shift_reg <= {bus.data_in, shift_reg[TOTAL_WIDTH-1:WORD_WIDTH]};
         word_cnt  <= last_word ? '0 : word_cnt + 1'b1;
      end
   end

   // Grid reset release lags DONE entry by one cycle and drops with start.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) grid_nreset_q <= 1'b0;
      else         grid_nreset_q <= (state == DONE) && !bus.start;
   end

   assign bus.config_out  = shift_reg[CONFIG_WIDTH-1:0];
   assign bus.config_done = (state == DONE);
   assign bus.grid_nreset = grid_nreset_q;

   // Padding bits of the last word are never exported to the grid.
   generate
      if (TOTAL_WIDTH > CONFIG_WIDTH) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^shift_reg[TOTAL_WIDTH-1:CONFIG_WIDTH];
      end
   endgenerate
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader
//   Randomized bench for config_loader. Expected config bus and CRC come from a
//   bit-level model of the bitstream kept in the bench.
module tb_config_loader;
   localparam int WW     = 32;
   localparam int CW     = 1314;
   localparam int NW     = (CW + WW - 1) / WW;
   localparam int BUDGET = 2000;
`ifdef CONFIG_LOADER_CRC_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic clock  = 1'b0;
   logic nreset = 1'b0;
   always #5 clock = ~clock;

   config_loader_if #(.WORD_WIDTH(WW), .CONFIG_WIDTH(CW)) bus ();

   config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
      .clock  (clock),
      .nreset (nreset),
      .bus    (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   logic [WW-1:0] stim [0:NW];
   logic [CW-1:0] exp_cfg;

   // Config bit i is bit (i mod WW) of word (i div WW) of the stream.
   function automatic logic [CW-1:0] model_cfg();
      logic [CW-1:0] r;
      for (int i = 0; i < CW; i++) r[i] = stim[i / WW][i % WW];
      return r;
   endfunction

   // CRC over the flattened bitstream, first word first, MSB of each word first.
   function automatic logic [15:0] model_crc();
      bit          q[$];
      logic [15:0] c;
      for (int w = 0; w < NW; w++)
         for (int b = WW - 1; b >= 0; b--) q.push_back(stim[w][b]);
      c = 16'hFFFF;
      foreach (q[i]) begin
         if (c[15] ^ q[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   task automatic fill_random();
      for (int i = 0; i <= NW; i++) stim[i] = $urandom;
   endtask

   task automatic finish_stim();
      exp_cfg = model_cfg();
`ifdef CONFIG_LOADER_CRC_EN
      stim[NW] = {16'($urandom), model_crc()};
`endif
   endtask

   task automatic do_start();
      @(negedge clock);
      bus.start      = 1'b1;
      bus.data_valid = 1'b0;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   // mode 0: valid always high, 1: valid toggles 1/0, 2: random valid.
   // Returns at the first negedge after the last accepted word.
   task automatic send_words(input int n, input int mode, output int cycles);
      int   idx;
      logic v;
      logic hs;
      idx    = 0;
      cycles = 0;
      while (idx < n && cycles < BUDGET) begin
         @(negedge clock);
         case (mode)
            0:       v = 1'b1;
            1:       v = (cycles % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.data_valid = v;
         bus.data_in    = stim[idx];
         hs = v && bus.data_ready;
         @(posedge clock);
         if (hs) idx++;
         cycles++;
      end
      @(negedge clock);
      bus.data_valid = 1'b0;
      total++;
      if (idx != n) begin
         bad++;
         $display("FAIL send_words timeout: accepted %0d of %0d words", idx, n);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.data_valid = 1'b0; bus.data_in = '0;
      nreset = 1'b0;
      repeat (3) @(negedge clock);
      total++; if (bus.config_out !== '0) begin bad++; $display("FAIL reset_config_out: got nonzero"); end
      total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL reset_data_ready: got %b want 0", bus.data_ready); end
      total++; if (bus.config_done !== 1'b0) begin bad++; $display("FAIL reset_config_done: got %b want 0", bus.config_done); end
      total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", bus.error); end
      total++; if (bus.grid_nreset !== 1'b0) begin bad++; $display("FAIL reset_grid_nreset: got %b want 0", bus.grid_nreset); end
      nreset = 1'b1;
      bus.data_valid = 1'b1;
      repeat (2) @(negedge clock);
      total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL idle_data_ready: got %b want 0", bus.data_ready); end
      bus.data_valid = 1'b0;
   endtask

   task automatic test_basic();
      int cyc;
      for (int k = 0; k < NW; k++) stim[k] = WW'(k);
      finish_stim();
      do_start();
      send_words(NW + EXTRA, 0, cyc);
      total++; if (cyc != NW + EXTRA) begin bad++; $display("FAIL basic_handshakes: got %0d want %0d", cyc, NW + EXTRA); end
      total++; if (bus.config_out !== exp_cfg) begin bad++; $display("FAIL basic_config_out: got %h want %h", bus.config_out[63:0], exp_cfg[63:0]); end
      total++; if (bus.config_out[31:0] !== 32'd0) begin bad++; $display("FAIL basic_word0: got %h want 0", bus.config_out[31:0]); end
      total++; if (bus.config_out[63:32] !== 32'd1) begin bad++; $display("FAIL basic_word1: got %h want 1", bus.config_out[63:32]); end
      total++; if (bus.config_done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", bus.config_done); end
      total++; if (bus.grid_nreset !== 1'b0) begin bad++; $display("FAIL basic_grid_early: got %b want 0", bus.grid_nreset); end
      bus.data_valid = 1'b1;
      bus.data_in    = 32'h1234_5678;
      @(negedge clock);
      total++; if (bus.grid_nreset !== 1'b1) begin bad++; $display("FAIL basic_grid_release: got %b want 1", bus.grid_nreset); end
      total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL basic_done_ready: got %b want 0", bus.data_ready); end
      total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", bus.error); end
      @(negedge clock);
      total++; if (bus.config_out !== exp_cfg) begin bad++; $display("FAIL basic_hold: config_out changed after done"); end
      bus.data_valid = 1'b0;
   endtask

   task automatic test_valid_toggle();
      int cyc;
      fill_random();
      finish_stim();
      do_start();
      send_words(NW + EXTRA, 1, cyc);
      total++; if (cyc != 2 * (NW + EXTRA) - 1) begin bad++; $display("FAIL toggle_cycles: got %0d want %0d", cyc, 2 * (NW + EXTRA) - 1); end
      total++; if (bus.config_out !== exp_cfg) begin bad++; $display("FAIL toggle_config_out: got %h want %h", bus.config_out[63:0], exp_cfg[63:0]); end
      total++; if (bus.config_done !== 1'b1) begin bad++; $display("FAIL toggle_done: got %b want 1", bus.config_done); end
   endtask

   task automatic test_last_word_ones();
      int cyc;
      fill_random();
      stim[NW-1] = 32'hFFFF_FFFF;
      finish_stim();
      do_start();
      send_words(NW + EXTRA, 2, cyc);
      total++; if (bus.config_out[CW-1:CW-2] !== 2'b11) begin bad++; $display("FAIL last_top_bits: got %b want 11", bus.config_out[CW-1:CW-2]); end
      total++; if (bus.config_out !== exp_cfg) begin bad++; $display("FAIL last_config_out: got %h want %h", bus.config_out[CW-1:CW-64], exp_cfg[CW-1:CW-64]); end
   endtask

   task automatic test_restart();
      int cyc;
      // Previous test left the loader in DONE; start must drop done/grid.
      do_start();
      total++; if (bus.config_done !== 1'b0) begin bad++; $display("FAIL restart_done_clear: got %b want 0", bus.config_done); end
      total++; if (bus.grid_nreset !== 1'b0) begin bad++; $display("FAIL restart_grid_clear: got %b want 0", bus.grid_nreset); end
      fill_random();
      send_words(20, 0, cyc);
      @(negedge clock);
      bus.start      = 1'b1;
      bus.data_valid = 1'b1;
      bus.data_in    = 32'hDEAD_BEEF;
      total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL restart_ready: got %b want 1", bus.data_ready); end
      @(negedge clock);
      bus.start      = 1'b0;
      bus.data_valid = 1'b0;
      total++; if (bus.config_out !== '0) begin bad++; $display("FAIL restart_cleared: got %h want 0", bus.config_out[63:0]); end
      for (int k = 0; k <= NW; k++) stim[k] = 32'hA5A5_A5A5;
      finish_stim();
      send_words(NW + EXTRA, 0, cyc);
      total++; if (bus.config_out !== exp_cfg) begin bad++; $display("FAIL restart_config_out: got %h want %h", bus.config_out[63:0], exp_cfg[63:0]); end
      total++; if (bus.config_done !== 1'b1) begin bad++; $display("FAIL restart_done: got %b want 1", bus.config_done); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      fill_random();
      finish_stim();
      do_start();
      send_words(30, 0, cyc);
      #2 nreset = 1'b0;
      #1;
      total++; if (bus.config_out !== '0) begin bad++; $display("FAIL midreset_config_out: got %h want 0", bus.config_out[63:0]); end
      total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL midreset_ready: got %b want 0", bus.data_ready); end
      total++; if (bus.config_done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b want 0", bus.config_done); end
      total++; if (bus.grid_nreset !== 1'b0) begin bad++; $display("FAIL midreset_grid: got %b want 0", bus.grid_nreset); end
      @(negedge clock);
      nreset = 1'b1;
      bus.data_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL midreset_idle_ready: cycle %0d got %b want 0", i, bus.data_ready); end
      end
      bus.data_valid = 1'b0;
      total++; if (bus.config_out !== '0) begin bad++; $display("FAIL midreset_no_load: got %h want 0", bus.config_out[63:0]); end
      do_start();
      send_words(NW + EXTRA, 2, cyc);
      total++; if (bus.config_out !== exp_cfg) begin bad++; $display("FAIL midreset_reload: got %h want %h", bus.config_out[63:0], exp_cfg[63:0]); end
      total++; if (bus.config_done !== 1'b1) begin bad++; $display("FAIL midreset_reload_done: got %b want 1", bus.config_done); end
   endtask

   task automatic test_random_loads();
      int cyc;
      for (int r = 0; r < 3; r++) begin
         fill_random();
         finish_stim();
         do_start();
         send_words(NW + EXTRA, 2, cyc);
         total++; if (bus.config_out !== exp_cfg) begin bad++; $display("FAIL random_config_out: load %0d got %h want %h", r, bus.config_out[63:0], exp_cfg[63:0]); end
         total++; if (bus.config_done !== 1'b1) begin bad++; $display("FAIL random_done: load %0d got %b want 1", r, bus.config_done); end
      end
   endtask

   task automatic test_crc();
`ifdef CONFIG_LOADER_CRC_EN
      int cyc;
      fill_random();
      finish_stim();
      do_start();
      send_words(NW + 1, 2, cyc);
      total++; if (bus.config_done !== 1'b1) begin bad++; $display("FAIL crc_good_done: got %b want 1", bus.config_done); end
      total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL crc_good_error: got %b want 0", bus.error); end
      @(negedge clock);
      total++; if (bus.grid_nreset !== 1'b1) begin bad++; $display("FAIL crc_good_grid: got %b want 1", bus.grid_nreset); end
      fill_random();
      finish_stim();
      stim[NW][0] = ~stim[NW][0];
      do_start();
      send_words(NW + 1, 2, cyc);
      total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL crc_bad_error: got %b want 1", bus.error); end
      total++; if (bus.config_done !== 1'b0) begin bad++; $display("FAIL crc_bad_done: got %b want 0", bus.config_done); end
      total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL crc_bad_ready: got %b want 0", bus.data_ready); end
      @(negedge clock);
      total++; if (bus.grid_nreset !== 1'b0) begin bad++; $display("FAIL crc_bad_grid: got %b want 0", bus.grid_nreset); end
      do_start();
      total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL crc_start_clears: got %b want 0", bus.error); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_valid_toggle();
      test_last_word_ones();
      test_restart();
      test_reset_mid();
      test_random_loads();
      test_crc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
